// File: rtl/dm_sbus_target.sv
// Memory-backed system-bus target: byte-enabled word writes/reads with an out-of-range error flag.
// Latency: response appears Latency cycles after the req&&gnt cycle, one response per transfer, in order.
// Backpressure: none on responses; gnt=req unless DM_SBUS_TARGET_STALL_EN adds LFSR-driven request stalls.
module dm_sbus_target #(
    parameter int unsigned          BusWidth = 32,
    parameter int unsigned          Depth    = 64,
    parameter logic [BusWidth-1:0]  BaseAddr = 32'h1000_0000,
    parameter int unsigned          Latency  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_req_i,
    input  logic [BusWidth-1:0]   slave_add_i,
    input  logic                  slave_we_i,
    input  logic [BusWidth-1:0]   slave_wdata_i,
    input  logic [BusWidth/8-1:0] slave_be_i,
    output logic                  slave_gnt_o,
    output logic                  slave_r_valid_o,
    output logic [BusWidth-1:0]   slave_r_rdata_o,
    output logic                  slave_r_err_o
);

    localparam int unsigned BeW  = BusWidth / 8;
    localparam int unsigned OffW = $clog2(BeW);
    localparam int unsigned IdxW = $clog2(Depth);
    localparam logic [BusWidth-1:0] DepthW = BusWidth'(Depth);

    logic                transfer;
    logic [BusWidth-1:0] off;
    logic [BusWidth-1:0] word;
    logic                in_range;
    logic [IdxW-1:0]     idx;
    logic [BusWidth-1:0] rsp_dat;
    logic                rsp_err;

    logic [BusWidth-1:0] mem_q [Depth];

    logic                vld_q [Latency];
    logic [BusWidth-1:0] dat_q [Latency];
    logic                err_q [Latency];

`ifdef DM_SBUS_TARGET_STALL_EN
    logic [15:0] lfsr_q;
    logic [3:0]  stall_cnt_q;
    logic        force_gnt;

    // After 8 consecutive withheld requesting cycles the 9th is granted unconditionally.
    assign force_gnt   = (stall_cnt_q == 4'd8);
    assign slave_gnt_o = slave_req_i && (!lfsr_q[0] || force_gnt);

    // Fibonacci LFSR (taps 16,14,13,11) free-runs; stall counter tracks the current withheld run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q      <= 16'hACE1;
            stall_cnt_q <= '0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            if (slave_req_i && !slave_gnt_o) begin
                stall_cnt_q <= stall_cnt_q + 4'd1;
            end else begin
                stall_cnt_q <= '0;
            end
        end
    end

    // A withheld request must be held unchanged by the initiator until granted.
    held_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slave_req_i && !slave_gnt_o) |=> (slave_req_i && $stable(slave_add_i) &&
        $stable(slave_we_i) && $stable(slave_wdata_i) && $stable(slave_be_i)));
`else
    assign slave_gnt_o = slave_req_i;
`endif

    assign transfer = slave_req_i && slave_gnt_o;

    // Decode: subtraction wraps, so addresses below the base land far out of range (no aliasing).
    always_comb begin
        off      = slave_add_i - BaseAddr;
        word     = off >> OffW;
        in_range = (slave_add_i >= BaseAddr) && (word < DepthW);
        idx      = word[IdxW-1:0];
        rsp_err  = transfer && !in_range;
        rsp_dat  = '0;
        if (transfer && !slave_we_i && in_range) begin
            rsp_dat = mem_q[idx];
        end
    end

    // Storage: cleared on reset, byte-lane writes on in-range write transfers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (transfer && slave_we_i && in_range) begin
            for (int k = 0; k < BeW; k++) begin
                if (slave_be_i[k]) begin
                    mem_q[idx][8*k +: 8] <= slave_wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Response shift pipeline: stage 0 captures every cycle, outputs come from the last stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            vld_q[0] <= transfer;
            dat_q[0] <= rsp_dat;
            err_q[0] <= rsp_err;
            for (int i = 1; i < Latency; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
                err_q[i] <= err_q[i-1];
            end
        end
    end

    assign slave_r_valid_o = vld_q[Latency-1];
    assign slave_r_rdata_o = dat_q[Latency-1];
    assign slave_r_err_o   = err_q[Latency-1];

endmodule
